// File: rtl/popcount_accumulator.sv
// popcount_accumulator
//   Sums NUM_WORDS successive popcount words (one per valid/ready beat) into a
//   neuron pre-activation. It presents the sum together with a binary activation
//   bit (sum >= threshold, unsigned). The threshold is sampled with word 0 of
//   each group.
//
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   flush       synchronous abort: drops the partial group and any held result
//   count       popcount word from popcount_tree (CNT_SIZE bits)
//   in_valid    count is valid
//   in_ready    stage can accept count this cycle
//   threshold   activation threshold (ACC_SIZE bits)
//   out_valid   result is valid
//   out_ready   consumer accepts the result
//   out_sum     accumulated group sum (ACC_SIZE bits)
//   out_bit     out_sum >= sampled threshold
//   busy        a group is partially accumulated
module popcount_accumulator #(
  parameter int CNT_SIZE  = 5,
  parameter int NUM_WORDS = 4,
  parameter int ACC_SIZE  = 7,
  parameter int IDX_SIZE  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [CNT_SIZE-1:0] count,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ACC_SIZE-1:0] threshold,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_SIZE-1:0] out_sum,
  output logic                out_bit,
  output logic                busy
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(NUM_WORDS - 1);

  state_t              state, state_next;
  logic [ACC_SIZE-1:0] acc;
  logic [ACC_SIZE-1:0] thr_q;
  logic [IDX_SIZE-1:0] word_idx;

  logic                drain;
  logic                beat;
  logic                first;
  logic                last;
  logic [ACC_SIZE-1:0] sum_c;
  logic [ACC_SIZE-1:0] thr_c;

  assign busy = (word_idx != '0);

  always_comb begin
    drain      = (state == HOLD) && out_ready;
    in_ready   = (state == ACC) || drain;
    beat       = in_valid && in_ready && !flush;
    first      = (word_idx == '0);
    last       = (word_idx == LAST_IDX);
    // Word 0 starts a fresh sum and compares against the live threshold, so a
    // single-word group never sees a stale accumulator or stale thr_q.
    sum_c      = first ? ACC_SIZE'(count) : acc + ACC_SIZE'(count);
    thr_c      = first ? threshold : thr_q;
    state_next = state;
    if (flush)
      state_next = ACC;
    else if (beat && last)
      state_next = HOLD;
    else if (drain)
      state_next = ACC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ACC;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      thr_q     <= '0;
      word_idx  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_bit   <= 1'b0;
    end else if (flush) begin
      acc       <= '0;
      word_idx  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (drain)
        out_valid <= 1'b0;
      if (beat) begin
        if (first)
          thr_q <= threshold;
        if (last) begin
          // Overrides the drain above when a new group completes in the same cycle.
          out_sum   <= sum_c;
          out_bit   <= (sum_c >= thr_c);
          out_valid <= 1'b1;
          word_idx  <= '0;
          acc       <= '0;
        end else begin
          acc      <= sum_c;
          word_idx <= word_idx + IDX_SIZE'(1);
        end
      end
    end
  end

endmodule
